// File: rtl/mic_ifu_pkg.sv
// Shared types, default sizes and byte-extension helpers for the MIC instruction fetch unit.
package mic_ifu_pkg;

    typedef enum logic [1:0] {
        IFU_IDLE,
        IFU_RUN,
        IFU_REDIR
    } ifu_state_t;

    localparam int DEF_QDEPTH = 4;
    localparam int DEF_PC_W   = 32;

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] zext8(input logic [7:0] b);
        return {24'h000000, b};
    endfunction

endpackage

// File: rtl/ifu_byte_queue.sv
// Circular byte FIFO for the fetch unit: one push and zero to two pops per cycle,
// synchronous flush, combinational head and head+1 read ports (zero when not present).
module ifu_byte_queue
    import mic_ifu_pkg::*;
#(
    parameter int  DEPTH = DEF_QDEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk_ifu,
    input  logic          reset_ifu_n,
    input  logic          flush,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic [1:0]    pop_cnt,
    output logic [CW-1:0] count,
    output logic [7:0]    head_data,
    output logic [7:0]    next_data
);

    logic [7:0]    storage [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_plus1;

    assign rd_ptr_plus1 = rd_ptr + AW'(1);

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours regardless of process order.
    always_ff @(posedge clk_ifu) begin
        if (!reset_ifu_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr + AW'(pop_cnt);
            count  <= count + CW'(push) - CW'(pop_cnt);
        end
    end

    // NOTE: the byte storage has no reset; count gates every read, so stale contents
    // are never visible and the array can map onto plain registers or LUT RAM.
    always_ff @(posedge clk_ifu) begin
        if (push && !flush) begin
            storage[wr_ptr] <= push_data;
        end
    end

    assign head_data = (count != '0)       ? storage[rd_ptr]       : 8'h00;
    assign next_data = (count >= CW'(2))   ? storage[rd_ptr_plus1] : 8'h00;

endmodule

// File: rtl/mic_fetch_unit.sv
// MIC instruction fetch unit: issues byte fetches, buffers returned bytes in a prefetch
// queue, presents MBR/MBRU/2-byte operand to the microsequencer and handles redirects.
module mic_fetch_unit
    import mic_ifu_pkg::*;
#(
    parameter int              QDEPTH   = DEF_QDEPTH,
    parameter int              PC_W     = DEF_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk_ifu,
    input  logic            reset_ifu_n,
    input  logic            ifu_en,
    output logic [PC_W-1:0] PC_M,
    output logic            Fetch,
    input  logic [7:0]      out_MBR,
    input  logic            take1,
    input  logic            take2,
    input  logic            pc_load,
    input  logic [PC_W-1:0] pc_new,
    output logic [31:0]     mbr_s,
    output logic [31:0]     mbru,
    output logic [15:0]     mbr2,
    output logic            mbr1_valid,
    output logic            mbr2_valid,
    output logic [PC_W-1:0] pc_head,
    output logic            underflow_err
);

    localparam int CW = $clog2(QDEPTH) + 1;

    ifu_state_t      state;
    ifu_state_t      state_next;
    logic [PC_W-1:0] fetch_pc;
    logic            inflight;
    logic            issue;
    logic            push;
    logic            underflow_set;
    logic [1:0]      pop_cnt;
    logic [CW-1:0]   count;
    logic [CW-1:0]   occupancy;
    logic [7:0]      head_byte;
    logic [7:0]      next_byte;

    // Bytes already queued plus the one on its way back; never exceeds QDEPTH.
    assign occupancy  = count + CW'(inflight);
    assign mbr1_valid = (count != '0);
    assign mbr2_valid = (count >= CW'(2));

    // NOTE: every signal driven here gets a default first, so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        unique case (state)
            IFU_IDLE: begin
                if (!pc_load && ifu_en) begin
                    state_next = IFU_RUN;
                end
            end
            IFU_RUN: begin
                if (pc_load) begin
                    state_next = IFU_REDIR;
                end else if (!ifu_en && !inflight) begin
                    state_next = IFU_IDLE;
                end else begin
                    issue = ifu_en && (occupancy < CW'(QDEPTH));
                end
            end
            IFU_REDIR: begin
                state_next = pc_load ? IFU_REDIR : IFU_RUN;
            end
            default: begin
                state_next = IFU_IDLE;
            end
        endcase
    end

    // Consume handshake; a redirect cycle ignores takes entirely.
    always_comb begin
        pop_cnt       = 2'd0;
        underflow_set = 1'b0;
        if (!pc_load) begin
            if (take2) begin
                if (mbr2_valid) pop_cnt = 2'd2;
                else            underflow_set = 1'b1;
            end else if (take1) begin
                if (mbr1_valid) pop_cnt = 2'd1;
                else            underflow_set = 1'b1;
            end
        end
    end

    // A byte returning in a redirect cycle belongs to the old stream and is dropped.
    assign push = inflight && !pc_load;

    always_ff @(posedge clk_ifu) begin
        if (!reset_ifu_n) begin
            state         <= IFU_IDLE;
            fetch_pc      <= RESET_PC;
            pc_head       <= RESET_PC;
            inflight      <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            state <= state_next;
            if (pc_load) begin
                fetch_pc <= pc_new;
                pc_head  <= pc_new;
                inflight <= 1'b0;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + PC_W'(1);
                end
                inflight <= issue;
                pc_head  <= pc_head + PC_W'(pop_cnt);
            end
            if (underflow_set) begin
                underflow_err <= 1'b1;
            end
        end
    end

    ifu_byte_queue #(
        .DEPTH(QDEPTH)
    ) u_queue (
        .clk_ifu    (clk_ifu),
        .reset_ifu_n(reset_ifu_n),
        .flush      (pc_load),
        .push       (push),
        .push_data  (out_MBR),
        .pop_cnt    (pop_cnt),
        .count      (count),
        .head_data  (head_byte),
        .next_data  (next_byte)
    );

    assign PC_M  = fetch_pc;
    assign Fetch = issue;
    assign mbr_s = sext8(head_byte);
    assign mbru  = zext8(head_byte);
    assign mbr2  = {head_byte, next_byte};

endmodule

// File: tb/tb_mic_fetch_unit.sv
// Self-checking bench for mic_fetch_unit: byte-memory model, transaction-level queue model
// compared every cycle, plus directed vectors with hand-computed literal expectations.
module tb_mic_fetch_unit;

    localparam int QDEPTH = 4;

    logic        clk_ifu = 1'b0;
    logic        reset_ifu_n;
    logic        ifu_en;
    logic [31:0] PC_M;
    logic        Fetch;
    logic [7:0]  out_MBR = 8'h00;
    logic        take1;
    logic        take2;
    logic        pc_load;
    logic [31:0] pc_new;
    logic [31:0] mbr_s;
    logic [31:0] mbru;
    logic [15:0] mbr2;
    logic        mbr1_valid;
    logic        mbr2_valid;
    logic [31:0] pc_head;
    logic        underflow_err;

    int checks = 0;
    int errors = 0;
    logic started = 1'b0;

    logic [7:0] img [256];
    logic [7:0] heads [6];

    mic_fetch_unit #(
        .QDEPTH  (QDEPTH),
        .PC_W    (32),
        .RESET_PC(32'h0)
    ) dut (
        .clk_ifu      (clk_ifu),
        .reset_ifu_n  (reset_ifu_n),
        .ifu_en       (ifu_en),
        .PC_M         (PC_M),
        .Fetch        (Fetch),
        .out_MBR      (out_MBR),
        .take1        (take1),
        .take2        (take2),
        .pc_load      (pc_load),
        .pc_new       (pc_new),
        .mbr_s        (mbr_s),
        .mbru         (mbru),
        .mbr2         (mbr2),
        .mbr1_valid   (mbr1_valid),
        .mbr2_valid   (mbr2_valid),
        .pc_head      (pc_head),
        .underflow_err(underflow_err)
    );

    always #5 clk_ifu = ~clk_ifu;

    // Fetch memory: registered byte, one cycle latency, reset tied to ~reset_ifu_n.
    always @(posedge clk_ifu) begin
        if (!reset_ifu_n) out_MBR <= 8'h00;
        else if (Fetch)   out_MBR <= img[PC_M[7:0]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: the queue as a list of bytes, plus the fetch stream it expects.
    logic [7:0]  m_q [$];
    logic [31:0] m_head  = 32'h0;
    logic [31:0] m_fpc   = 32'h0;
    logic [31:0] m_paddr = 32'h0;
    logic        m_pend  = 1'b0;
    logic        m_err   = 1'b0;
    logic        m_run   = 1'b0;
    int          m_hold  = 0;
    int          sz;
    logic        fe;
    logic        old_pend;
    logic [7:0]  h;
    logic [7:0]  n;

    always @(negedge clk_ifu) begin
        sz = m_q.size();
        h  = (sz >= 1) ? m_q[0] : 8'h00;
        n  = (sz >= 2) ? m_q[1] : 8'h00;
        fe = m_run && (m_hold == 0) && ifu_en && !pc_load && (sz + int'(m_pend) < QDEPTH);
        if (started) begin
            check("fetch", Fetch, fe);
            check("pc_m", PC_M, m_fpc);
            check("mbr1_valid", mbr1_valid, sz >= 1);
            check("mbr2_valid", mbr2_valid, sz >= 2);
            check("mbru", mbru, 32'(h));
            check("mbr_s", mbr_s, (h >= 8'h80) ? 32'(h) + 32'hFFFFFF00 : 32'(h));
            check("mbr2", mbr2, 16'(h) * 16'd256 + 16'(n));
            check("pc_head", pc_head, m_head);
            check("underflow_err", underflow_err, m_err);
        end
        // Advance the model to the state after the coming clock edge.
        if (!reset_ifu_n) begin
            m_q.delete();
            m_head = 32'h0; m_fpc = 32'h0; m_pend = 1'b0;
            m_err  = 1'b0;  m_run = 1'b0;  m_hold = 0;
        end else if (pc_load) begin
            m_q.delete();
            m_head = pc_new; m_fpc = pc_new; m_pend = 1'b0;
            if (m_run) m_hold = 1;
        end else begin
            old_pend = m_pend;
            if (take2) begin
                if (sz >= 2) begin
                    void'(m_q.pop_front()); void'(m_q.pop_front());
                    m_head = m_head + 32'd2;
                end else m_err = 1'b1;
            end else if (take1) begin
                if (sz >= 1) begin
                    void'(m_q.pop_front());
                    m_head = m_head + 32'd1;
                end else m_err = 1'b1;
            end
            if (m_pend) m_q.push_back(img[m_paddr[7:0]]);
            m_pend = fe;
            if (fe) begin
                m_paddr = m_fpc;
                m_fpc   = m_fpc + 32'd1;
            end
            if (!m_run) begin
                if (ifu_en) m_run = 1'b1;
            end else if (m_hold > 0) begin
                m_hold--;
            end else if (!ifu_en && !old_pend) begin
                m_run = 1'b0;
            end
        end
    end

    task automatic set_in(input logic en, input logic t1, input logic t2,
                          input logic pl, input logic [31:0] pn);
        ifu_en = en; take1 = t1; take2 = t2; pc_load = pl; pc_new = pn;
    endtask

    task automatic next_cycle();
        @(posedge clk_ifu);
        #2;
    endtask

    task automatic mid();
        @(negedge clk_ifu);
    endtask

    logic [2:0] mix [10];

    initial begin
        for (int i = 0; i < 256; i++) img[i] = 8'(i * 37 + 11);
        img[0] = 8'h00; img[1] = 8'hAD; img[2] = 8'h1D;
        img[3] = 8'hAD; img[4] = 8'h1E; img[5] = 8'h18;
        heads = '{8'h00, 8'hAD, 8'h1D, 8'hAD, 8'h1E, 8'h18};
        mix   = '{3'b110, 3'b101, 3'b111, 3'b100, 3'b110,
                  3'b001, 3'b010, 3'b000, 3'b000, 3'b000};
        reset_ifu_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset state
        next_cycle(); started = 1'b1;
        mid();
        check("lit_rst_fetch", Fetch, 0);
        check("lit_rst_pc_m", PC_M, 0);
        check("lit_rst_valid1", mbr1_valid, 0);
        check("lit_rst_valid2", mbr2_valid, 0);
        check("lit_rst_mbru", mbru, 0);
        check("lit_rst_err", underflow_err, 0);

        // Fill from address 0
        next_cycle(); reset_ifu_n = 1'b1; set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        mid(); check("lit_idle_no_fetch", Fetch, 0);
        next_cycle();
        mid(); check("lit_first_fetch", Fetch, 1); check("lit_first_pc_m", PC_M, 0);
        repeat (3) next_cycle();
        next_cycle();
        mid(); check("lit_full_fetch_drop", Fetch, 0);

        // Stream consumption with take1 every cycle
        for (int i = 0; i < 6; i++) begin
            next_cycle(); set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            mid();
            check("lit_stream_head", mbru, 32'(heads[i]));
            if (i == 0) check("lit_full_no_fetch", Fetch, 0);
            if (i == 1) check("lit_mbr_s_ad", mbr_s, 32'hFFFFFFAD);
        end
        next_cycle(); set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        mid(); check("lit_stream_pc_head", pc_head, 32'd6); check("lit_stream_no_err", underflow_err, 0);

        // Redirect to 1, then take2 of the operand AD1D
        next_cycle(); set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'd1);
        mid(); check("lit_redir_no_fetch", Fetch, 0);
        next_cycle(); set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        mid(); check("lit_redir_flushed", mbr1_valid, 0); check("lit_redir_pc_head", pc_head, 32'd1);
        next_cycle();
        mid(); check("lit_redir_fetch_pc", PC_M, 32'd1); check("lit_redir_fetch", Fetch, 1);
        next_cycle();
        next_cycle();
        next_cycle(); set_in(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        mid(); check("lit_mbr2_ad1d", mbr2, 16'hAD1D); check("lit_take2_pc_before", pc_head, 32'd1);
        next_cycle(); set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        mid(); check("lit_take2_pc_after", pc_head, 32'd3); check("lit_take2_head", mbru, 32'h000000AD);
        next_cycle();

        // Redirect to 5 while the queue is nearly full with a byte in flight
        next_cycle(); set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'd5);
        mid(); check("lit_flush_no_fetch", Fetch, 0);
        next_cycle(); set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        mid(); check("lit_flush_empty", mbr1_valid, 0); check("lit_flush_pc_head", pc_head, 32'd5);
        next_cycle();
        mid(); check("lit_flush_refetch", PC_M, 32'd5);
        next_cycle();
        mid(); check("lit_stale_dropped", mbr1_valid, 0);
        next_cycle(); set_in(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        mid(); check("lit_redir_head_18", mbru, 32'h18); check("lit_one_byte", mbr2_valid, 0);

        // Underflow with a single byte, then sticky
        next_cycle(); set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        mid();
        check("lit_underflow_set", underflow_err, 1);
        check("lit_underflow_no_pop", pc_head, 32'd5);
        check("lit_underflow_mbr2", mbr2, 16'h18E9);
        for (int i = 0; i < 10; i++) begin
            next_cycle(); set_in(mix[i][2], mix[i][1], mix[i][0], 1'b0, 32'h0);
        end

        // Redirect while idle to a wrapping address, then re-enable
        next_cycle(); set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE);
        next_cycle(); set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        mid(); check("lit_idle_load_no_fetch", Fetch, 0);
        next_cycle();
        next_cycle();
        mid(); check("lit_wrap_pc_m", PC_M, 32'hFFFFFFFF);
        next_cycle(); set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) next_cycle();
        next_cycle(); set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        mid();
        check("lit_wrap_pc_head", pc_head, 32'd2);
        check("lit_wrap_head", mbru, 32'h1D);
        check("lit_err_sticky", underflow_err, 1);

        // Reset for one cycle in the middle of a refill
        next_cycle(); set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'd2);
        next_cycle(); set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) next_cycle();
        next_cycle(); reset_ifu_n = 1'b0;
        next_cycle(); reset_ifu_n = 1'b1;
        mid();
        check("lit_mrst_fetch", Fetch, 0);
        check("lit_mrst_pc_m", PC_M, 0);
        check("lit_mrst_valid", mbr1_valid, 0);
        check("lit_mrst_pc_head", pc_head, 0);
        check("lit_mrst_err", underflow_err, 0);
        next_cycle();
        mid(); check("lit_refill_fetch", Fetch, 1); check("lit_refill_pc_m", PC_M, 0);
        next_cycle();
        next_cycle();
        mid(); check("lit_refill_valid", mbr1_valid, 1); check("lit_refill_head", mbru, 0);
        next_cycle();
        mid(); check("lit_refill_mbr2", mbr2, 16'h00AD);
        repeat (4) next_cycle();
        mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
